frv_pipeline_writeback: RTL

//  Final backend stage; consumes the s4 handshake from the memory stage.

---
 rtl/frv_pipeline_writeback_pkg.sv | 17 +
 rtl/frv_pipeline_writeback_if.sv | 23 ++
 rtl/frv_lsu_rdata_align.sv | 20 ++
 rtl/frv_pipeline_writeback.sv | 81 ++++++++
 4 files changed

// File: rtl/frv_pipeline_writeback_pkg.sv
// frv_pipeline_writeback_pkg: shared widths, field indices and FSM encoding for the writeback stage
package frv_pipeline_writeback_pkg;
  localparam int XLEN = 32;
  localparam int XL = XLEN - 1;
  localparam int P_FU_LSU = 1;
  localparam int P_FU_CFU = 2;
  localparam int P_FU_CSR = 3;
  localparam int LSU_SIGNED = 0;
  localparam int LSU_WIDTH = 1;
  localparam int LSU_LOAD = 3;
  localparam int LSU_STORE = 4;
  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_MEM,
    WB_WAIT_CF
  } wb_state_e;
endpackage

// File: rtl/frv_pipeline_writeback_if.sv
// frv_pipeline_writeback_if: s4 handshake bundle from the memory stage into writeback
interface frv_pipeline_writeback_if;
  import frv_pipeline_writeback_pkg::*;
  logic s4_p_valid;
  logic s4_p_busy;
  logic [4:0] s4_rd;
  logic [XL:0] s4_wdata;
  logic s4_cf;
  logic [XL:0] s4_cft;
  logic [31:0] s4_pc;
  logic [31:0] s4_instr;
  logic [4:0] s4_uop;
  logic [4:0] s4_fu;
  logic s4_trap;
  modport master (
    output s4_p_valid, s4_rd, s4_wdata, s4_cf, s4_cft, s4_pc, s4_instr, s4_uop, s4_fu, s4_trap,
    input  s4_p_busy
  );
  modport slave (
    input  s4_p_valid, s4_rd, s4_wdata, s4_cf, s4_cft, s4_pc, s4_instr, s4_uop, s4_fu, s4_trap,
    output s4_p_busy
  );
endinterface

// File: rtl/frv_lsu_rdata_align.sv
// frv_lsu_rdata_align: picks the addressed byte/half/word from a load response and extends it
module frv_lsu_rdata_align
  import frv_pipeline_writeback_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  width_i,
  input  logic        signed_i,
  output logic [XL:0] data_o
);
  logic [7:0] b;
  logic [15:0] h;
  // select lane by address, then sign- or zero-extend by access width
  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = rdata_i[{addr_i[1], 4'b0000} +: 16];
    data_o = width_i == 2'b01 ? {{(XLEN-8){signed_i & b[7]}}, b} :
             width_i == 2'b10 ? {{(XLEN-16){signed_i & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/frv_pipeline_writeback.sv
// frv_pipeline_writeback: completes s4 instructions, waiting on memory responses and control-flow acks
module frv_pipeline_writeback
  import frv_pipeline_writeback_pkg::*;
#(
  parameter logic [4:0] TRAP_LD_FAULT = 5'd5,
  parameter logic [4:0] TRAP_ST_FAULT = 5'd7
) (
  input  logic                            g_clk,
  input  logic                            g_resetn,
  frv_pipeline_writeback_if.slave         s4,
  input  logic                            dmem_recv_i,
  input  logic [31:0]                     dmem_rdata_i,
  input  logic                            dmem_error_i,
  output logic                            gpr_wen_o,
  output logic [4:0]                      gpr_rd_o,
  output logic [XL:0]                     gpr_wdata_o,
  output logic [4:0]                      fwd_s4_rd_o,
  output logic [XL:0]                     fwd_s4_wdata_o,
  output logic                            fwd_s4_load_o,
  output logic                            fwd_s4_csr_o,
  output logic                            cf_req_o,
  output logic [XL:0]                     cf_target_o,
  input  logic                            cf_ack_i,
  output logic                            trap_raise_o,
  output logic [4:0]                      trap_cause_o,
  output logic [31:0]                     trap_pc_o,
  output logic                            trs_valid_o,
  output logic [31:0]                     trs_pc_o,
  output logic [31:0]                     trs_instr_o
);
  wb_state_e state_q, state_d;
  logic v, idle, ld, st, is_tr, is_mem, is_cf, is_alu;
  logic mem_done, mem_err, cf_done, done, ret, wen;
  logic [XL:0] ld_data;

  frv_lsu_rdata_align u_align (
    .rdata_i  (dmem_rdata_i),
    .addr_i   (s4.s4_wdata[1:0]),
    .width_i  (s4.s4_uop[LSU_WIDTH +: 2]),
    .signed_i (s4.s4_uop[LSU_SIGNED]),
    .data_o   (ld_data)
  );

  // FSM register; reset abandons any instruction still waiting
  always_ff @(posedge g_clk) state_q <= g_resetn ? state_d : WB_IDLE;

  // classify the s4 instruction, decide completion and drive every output combinationally
  always_comb begin
    v = g_resetn & s4.s4_p_valid;
    idle = state_q == WB_IDLE;
    ld = s4.s4_fu[P_FU_LSU] & s4.s4_uop[LSU_LOAD];
    st = s4.s4_fu[P_FU_LSU] & s4.s4_uop[LSU_STORE];
    is_tr = v & idle & s4.s4_trap;
    is_mem = g_resetn & (state_q == WB_WAIT_MEM | (v & idle & !s4.s4_trap & (ld | st)));
    is_cf = g_resetn & (state_q == WB_WAIT_CF | (v & idle & !s4.s4_trap & !(ld | st) & s4.s4_cf));
    is_alu = v & idle & !s4.s4_trap & !(ld | st) & !s4.s4_cf;
    mem_done = is_mem & dmem_recv_i;
    mem_err = mem_done & dmem_error_i;
    cf_done = is_cf & cf_ack_i;
    done = is_tr | is_alu | mem_done | cf_done;
    ret = is_alu | cf_done | (mem_done & !dmem_error_i);
    wen = (is_alu | cf_done | (mem_done & !dmem_error_i & ld)) & |s4.s4_rd;
    s4.s4_p_busy = (is_mem | is_cf) & !done;
    state_d = !s4.s4_p_busy ? WB_IDLE : is_mem ? WB_WAIT_MEM : WB_WAIT_CF;
    gpr_wen_o = wen;
    gpr_rd_o = wen ? s4.s4_rd : '0;
    gpr_wdata_o = !wen ? '0 : is_mem ? ld_data : s4.s4_wdata;
    fwd_s4_rd_o = (v & !s4.s4_trap & !st) ? s4.s4_rd : '0;
    fwd_s4_wdata_o = g_resetn ? s4.s4_wdata : '0;
    fwd_s4_load_o = v & ld & !done;
    fwd_s4_csr_o = v & s4.s4_fu[P_FU_CSR];
    cf_req_o = is_cf;
    cf_target_o = is_cf ? s4.s4_cft : '0;
    trap_raise_o = is_tr | mem_err;
    trap_cause_o = is_tr ? s4.s4_rd : mem_err ? (ld ? TRAP_LD_FAULT : TRAP_ST_FAULT) : '0;
    trap_pc_o = (is_tr | mem_err) ? s4.s4_pc : '0;
    trs_valid_o = ret;
    trs_pc_o = ret ? s4.s4_pc : '0;
    trs_instr_o = ret ? s4.s4_instr : '0;
  end
endmodule
